// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digits are 4-bit BCD nibbles, packed least-significant digit first.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int MAX_DIGITS  = 16;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    // All-nines pattern for the lowest 'digits' digits; upper digits stay zero.
    function automatic logic [BCD_DIGIT_W*MAX_DIGITS-1:0] max_bcd(input int digits);
        logic [BCD_DIGIT_W*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'h9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// bcd/ovf only change on the edge that raises done, so a display never sees partial results.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf,
    output conv_state_t                   dbg_state
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BCD_DIGIT_W*MAX_DIGITS-1:0] ALL_NINES_FULL = max_bcd(DIGITS);
    localparam logic [BW-1:0] ALL_NINES = ALL_NINES_FULL[BW-1:0];

    if (WIDTH < 1 || DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_params
        $error("bin_to_bcd_seq: WIDTH must be >= 1 and DIGITS in 1..MAX_DIGITS");
    end

    conv_state_t     state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [BW-1:0]         adjusted;
    logic [BW+WIDTH:0]     shift_cat;
    logic [BW-1:0]         shift_scratch;
    logic [WIDTH-1:0]      shift_bin;
    logic                  shift_out;
    logic                  final_sticky;
    logic                  bad_digit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // {scratch, binary} shifted left by one; the MSB is what falls off the top digit.
    assign shift_cat     = {adjusted, bin_q, 1'b0};
    assign shift_out     = shift_cat[BW+WIDTH];
    assign shift_scratch = shift_cat[BW+WIDTH-1:WIDTH];
    assign shift_bin     = shift_cat[WIDTH-1:0];
    assign final_sticky  = sticky_q | shift_out;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shift_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    bin_d     = bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CW'(WIDTH);
                end
            end
            SHIFT: begin
                bin_d     = shift_bin;
                scratch_d = shift_scratch;
                sticky_d  = final_sticky;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (final_sticky || bad_digit) begin
                        bcd_d = ALL_NINES;
                        ovf_d = 1'b1;
                    end else begin
                        bcd_d = shift_scratch;
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an 8-bit and a 10-bit instance on one clock,
// checked against a decimal arithmetic reference model.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    logic        clk;
    logic        reset;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8, done8, ovf8;
    logic [11:0] bcd8;
    conv_state_t st8;

    logic        start10;
    logic [9:0]  bin10;
    logic        busy10, done10, ovf10;
    logic [11:0] bcd10;
    conv_state_t st10;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [12:0] exp_q[$];

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8), .dbg_state(st8)
    );

    bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .bin(bin10),
        .busy(busy10), .done(done10), .bcd(bcd10), .ovf(ovf10), .dbg_state(st10)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {ovf, bcd} from plain decimal arithmetic.
    function automatic logic [12:0] ref_model(input int v, input int digits);
        int lim;
        int r;
        logic [11:0] b;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        if (v >= lim) return {1'b1, 12'h999};
        b = '0;
        r = v;
        for (int i = 0; i < digits; i++) begin
            b[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {1'b0, b};
    endfunction

    // One conversion on the selected instance. k is the sample index at which done
    // was seen (first sample after the accepting edge is k=1).
    task automatic run_conv(input bit wide, input int v, input int junk, input bit glitch,
                            output logic [11:0] b, output logic o,
                            output int nbusy, output int k, output logic got_done);
        @(negedge clk);
        if (wide) begin start10 = 1'b1; bin10 = v[9:0]; end
        else      begin start8  = 1'b1; bin8  = v[7:0]; end
        @(negedge clk);
        k = 1;
        nbusy = 0;
        start8 = 1'b0;
        start10 = 1'b0;
        while (!(wide ? done10 : done8) && k < 40) begin
            if (wide ? busy10 : busy8) nbusy++;
            if (wide) bin10 = junk[9:0]; else bin8 = junk[7:0];
            if (glitch) begin
                if (wide) start10 = 1'($urandom_range(0, 1));
                else      start8  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        start8 = 1'b0;
        start10 = 1'b0;
        got_done = wide ? done10 : done8;
        b = wide ? bcd10 : bcd8;
        o = wide ? ovf10 : ovf8;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b0; bin8 = '0;
        start10 = 1'b0; bin10 = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy8, done8, ovf8, bcd8} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset8: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy8, done8, ovf8, bcd8);
        end
        tests_run++;
        if ({busy10, done10, ovf10, bcd10} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset10: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy10, done10, ovf10, bcd10);
        end
        tests_run++;
        if (st8 !== IDLE || st10 !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: st8=%0d st10=%0d, required IDLE", st8, st10);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [11:0] b; logic o; int nb; int k; logic gd;
        run_conv(1'b0, 0, 0, 1'b0, b, o, nb, k, gd);
        tests_run++;
        if (gd !== 1'b1 || k != 9) begin
            tests_failed++;
            $display("FAIL zero_latency: done=%b at sample %0d, required done at 9", gd, k);
        end
        tests_run++;
        if (nb != 8) begin
            tests_failed++;
            $display("FAIL zero_busy: busy cycles %0d, required 8", nb);
        end
        tests_run++;
        if (b !== 12'h000 || o !== 1'b0 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_result: bcd=%h ovf=%b busy=%b, required 000 0 0", b, o, busy8);
        end
    endtask

    task automatic test_basic();
        int          vals[3];
        logic [11:0] exps[3];
        logic [11:0] b; logic o; int nb; int k; logic gd;
        vals = '{255, 128, 9};
        exps = '{12'h255, 12'h128, 12'h009};
        for (int i = 0; i < 3; i++) begin
            run_conv(1'b0, vals[i], 8'hAA, 1'b0, b, o, nb, k, gd);
            tests_run++;
            if (gd !== 1'b1 || k != 9 || nb != 8) begin
                tests_failed++;
                $display("FAIL basic_timing[%0d]: done=%b k=%0d busy=%0d, required 1 9 8", vals[i], gd, k, nb);
            end
            tests_run++;
            if (b !== exps[i] || o !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_value[%0d]: bcd=%h ovf=%b, required %h 0", vals[i], b, o, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int bad_pos;
        int bad_busy;
        int bad_val;
        ndone = 0; bad_pos = 0; bad_busy = 0; bad_val = 0;
        @(negedge clk);
        start8 = 1'b1;
        bin8 = 8'd42;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (k % 9 != 0) bad_pos++;
                if (bcd8 !== 12'h042 || ovf8 !== 1'b0) bad_val++;
            end
            if (busy8 === done8) bad_busy++;
        end
        start8 = 1'b0;
        tests_run++;
        if (ndone != 3 || bad_pos != 0) begin
            tests_failed++;
            $display("FAIL b2b_done: %0d pulses, %0d misplaced, required 3 at every 9th cycle", ndone, bad_pos);
        end
        tests_run++;
        if (bad_val != 0) begin
            tests_failed++;
            $display("FAIL b2b_value: %0d results differ from 042", bad_val);
        end
        tests_run++;
        if (bad_busy != 0) begin
            tests_failed++;
            $display("FAIL b2b_busy: %0d cycles where busy did not equal !done", bad_busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stop: busy=%b done=%b after start drop, required 0 0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        @(negedge clk);
        start8 = 1'b1;
        bin8 = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_busy: busy=%b in 4th busy cycle, required 1", busy8);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h000 || ovf8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_clear: busy=%b done=%b bcd=%h ovf=%b, required 0 0 000 0",
                     busy8, done8, bcd8, ovf8);
        end
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: %0d cycles with busy/done after abort, required 0", spurious);
        end
    endtask

    task automatic test_wide();
        int          vals[3];
        logic [11:0] eb[3];
        logic        eo[3];
        logic [11:0] b; logic o; int nb; int k; logic gd;
        vals = '{1023, 999, 1000};
        eb = '{12'h999, 12'h999, 12'h999};
        eo = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_conv(1'b1, vals[i], 10'h2AA, 1'b0, b, o, nb, k, gd);
            tests_run++;
            if (gd !== 1'b1 || k != 11 || nb != 10) begin
                tests_failed++;
                $display("FAIL wide_timing[%0d]: done=%b k=%0d busy=%0d, required 1 11 10", vals[i], gd, k, nb);
            end
            tests_run++;
            if (b !== eb[i] || o !== eo[i]) begin
                tests_failed++;
                $display("FAIL wide_value[%0d]: bcd=%h ovf=%b, required %h %b", vals[i], b, o, eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] b; logic o; int nb; int k; logic gd;
        logic [12:0] e;
        int          v;
        bit          wide;
        for (int i = 0; i < 24; i++) begin
            wide = (i % 3 == 2);
            v = wide ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 255));
            e = ref_model(v, 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_conv(wide, v, int'($urandom), 1'b1, b, o, nb, k, gd);
            tests_run++;
            if (gd !== 1'b1 || k != (wide ? 11 : 9)) begin
                tests_failed++;
                $display("FAIL rand_timing[%0d]: done=%b k=%0d, required done at %0d", v, gd, k, wide ? 11 : 9);
            end
            tests_run++;
            if ({o, b} !== e) begin
                tests_failed++;
                $display("FAIL rand_value[%0d]: ovf=%b bcd=%h, required ovf=%b bcd=%h", v, o, b, e[12], e[11:0]);
            end
        end
    endtask

    task automatic test_sweep();
        int          next;
        int          nres;
        int          cyc;
        logic [12:0] prev;
        logic [12:0] e;
        @(negedge clk);
        start8 = 1'b1;
        bin8 = 8'd0;
        exp_q.push_back(ref_model(0, 3));
        next = 1;
        nres = 0;
        cyc = 0;
        prev = {ovf8, bcd8};
        while (nres < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sweep_extra_done: unexpected done, bcd=%h", bcd8);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf8, bcd8} !== e) begin
                        tests_failed++;
                        $display("FAIL sweep_value[%0d]: ovf=%b bcd=%h, required ovf=%b bcd=%h",
                                 nres, ovf8, bcd8, e[12], e[11:0]);
                    end
                end
                nres++;
                if (next < 256) begin
                    bin8 = 8'(next);
                    exp_q.push_back(ref_model(next, 3));
                    next++;
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                tests_run++;
                if ({ovf8, bcd8} !== prev) begin
                    tests_failed++;
                    $display("FAIL sweep_hold: ovf/bcd changed to %b/%h from %b/%h without done",
                             ovf8, bcd8, prev[12], prev[11:0]);
                end
            end
            prev = {ovf8, bcd8};
        end
        start8 = 1'b0;
        tests_run++;
        if (nres != 256) begin
            tests_failed++;
            $display("FAIL sweep_count: %0d results in %0d cycles, required 256", nres, cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; bin8 = '0;
        start10 = 1'b0; bin10 = '0;
        test_reset();
        test_zero();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_random();
        test_sweep();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
